uart_dbus_bridge: RTL and testbench

//  Bus initiator that turns a byte stream from a UART receiver into VexRiscv-style dBus

---
 rtl/uart_dbus_pkg.sv | 22 ++
 rtl/timeout_counter.sv | 36 +++
 rtl/uart_dbus_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_uart_dbus_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbus_pkg.sv
// Shared opcodes, reply codes and FSM state encoding for the UART-to-dBus debug bridge.
package uart_dbus_pkg;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam int unsigned REPLY_BYTES = 5;
  localparam int unsigned REPLY_W     = REPLY_BYTES * 8;
  localparam logic [1:0]  SIZE_WORD   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CMD,
    RSP,
    REPLY
  } state_e;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter that raises expired_o after CYCLES consecutive tick_i cycles since the last load_i.
module timeout_counter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          expired_q;

  // Load has priority; once expired the flag holds until the next load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (load_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (tick_i && !expired_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        expired_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/uart_dbus_bridge.sv
// Host debug master: parses W/R byte frames from the UART, issues dBus word commands,
// and streams ACK/NAK plus read data back to the UART transmitter.
module uart_dbus_bridge
  import uart_dbus_pkg::*;
#(
  parameter int unsigned CLK_FREQ            = 100000000,
  parameter int unsigned WL                  = 32,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter int unsigned RSP_TIMEOUT_CYCLES  = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_rdy,
  output logic          tx_vld,
  output logic [7:0]    tx_data,
  output logic          dbus_cmd_valid,
  input  logic          dbus_cmd_ready,
  output logic          dbus_cmd_payload_wr,
  output logic [WL-1:0] dbus_cmd_payload_address,
  output logic [WL-1:0] dbus_cmd_payload_data,
  output logic [1:0]    dbus_cmd_payload_size,
  input  logic          dbus_rsp_ready,
  input  logic          dbus_rsp_error,
  input  logic [WL-1:0] dbus_rsp_data,
  output logic          busy
);

  state_e               state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [WL-1:0]        addr_q, addr_d;
  logic [WL-1:0]        data_q, data_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [REPLY_W-1:0]   rep_q, rep_d;
  logic [2:0]           rep_len_q, rep_len_d;
  logic                 tx_vld_q, tx_vld_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_hold_q, tx_hold_d;
  logic                 busy_q, busy_d;

  logic                 in_frame_c;
  logic                 byte_exp_c;
  logic                 rsp_exp_c;

  assign in_frame_c = (state_q == ADDR) || (state_q == DATA);

  // Inter-byte gap watchdog: restarted by every accepted frame byte.
  timeout_counter #(.CYCLES(BYTE_TIMEOUT_CYCLES)) u_byte_to (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (!in_frame_c || rx_valid),
    .tick_i    (in_frame_c),
    .expired_o (byte_exp_c)
  );

  timeout_counter #(.CYCLES(RSP_TIMEOUT_CYCLES)) u_rsp_to (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (state_q != RSP),
    .tick_i    (state_q == RSP),
    .expired_o (rsp_exp_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      rep_q       <= '0;
      rep_len_q   <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_hold_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      rep_q       <= rep_d;
      rep_len_q   <= rep_len_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      tx_hold_q   <= tx_hold_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    rep_len_d = rep_len_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    // The cycle after a tx pulse is blind to tx_rdy while the UART catches up.
    tx_hold_d = tx_vld_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            op_wr_d = (rx_data == OP_WR);
            state_d = ADDR;
          end else begin
            rep_d     = {NAK, {(REPLY_W-8){1'b0}}};
            rep_len_d = 3'd1;
            state_d   = REPLY;
          end
        end
      end
      ADDR: begin
        if (byte_exp_c) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          addr_d = {addr_q[WL-9:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = op_wr_q ? DATA : CMD;
          end
        end
      end
      DATA: begin
        if (byte_exp_c) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          data_d = {data_q[WL-9:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = CMD;
          end
        end
      end
      CMD: begin
        if (cmd_valid_q && dbus_cmd_ready) begin
          if (op_wr_q) begin
            rep_d     = {ACK, {(REPLY_W-8){1'b0}}};
            rep_len_d = 3'd1;
            state_d   = REPLY;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (dbus_rsp_ready) begin
          if (dbus_rsp_error) begin
            rep_d     = {NAK, {(REPLY_W-8){1'b0}}};
            rep_len_d = 3'd1;
          end else begin
            rep_d     = {ACK, dbus_rsp_data};
            rep_len_d = 3'(REPLY_BYTES);
          end
          state_d = REPLY;
        end else if (rsp_exp_c) begin
          rep_d     = {NAK, {(REPLY_W-8){1'b0}}};
          rep_len_d = 3'd1;
          state_d   = REPLY;
        end
      end
      REPLY: begin
        // Stay until the last pulse and its blind cycle are over.
        if (rep_len_q == 3'd0) begin
          if (!tx_vld_q && !tx_hold_q) begin
            state_d = IDLE;
          end
        end else if (tx_rdy && !tx_vld_q && !tx_hold_q) begin
          tx_vld_d  = 1'b1;
          tx_data_d = rep_q[REPLY_W-1 -: 8];
          rep_d     = {rep_q[REPLY_W-9:0], 8'h00};
          rep_len_d = rep_len_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_valid_d = (state_d == CMD);
    busy_d      = (state_d != IDLE);
  end

  assign tx_vld                   = tx_vld_q;
  assign tx_data                  = tx_data_q;
  assign dbus_cmd_valid           = cmd_valid_q;
  assign dbus_cmd_payload_wr      = op_wr_q;
  assign dbus_cmd_payload_address = {addr_q[WL-1:2], 2'b00};
  assign dbus_cmd_payload_data    = data_q;
  assign dbus_cmd_payload_size    = SIZE_WORD;
  assign busy                     = busy_q;

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Scoreboard bench for uart_dbus_bridge: expected bus commands and tx bytes are queued
// as frames are sent and retired by the bus and UART-side monitors.
module tb_uart_dbus_bridge;

  localparam int unsigned BTO = 200;
  localparam int unsigned RTO = 64;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  hold;
  } cmd_t;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_size;
  logic        rsp_ready;
  logic        rsp_error;
  logic [31:0] rsp_data;
  logic        busy;

  logic [7:0]  exp_tx[$];
  cmd_t        exp_cmd[$];
  int          n_checks;
  int          n_pass;
  int          stall_req;
  int          rsp_mode;   // 0 data, 1 error, 2 silent
  logic [31:0] rsp_word;
  int          tx_gap;

  uart_dbus_bridge #(
    .BYTE_TIMEOUT_CYCLES (BTO),
    .RSP_TIMEOUT_CYCLES  (RTO)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .rx_valid                 (rx_valid),
    .rx_data                  (rx_data),
    .tx_rdy                   (tx_rdy),
    .tx_vld                   (tx_vld),
    .tx_data                  (tx_data),
    .dbus_cmd_valid           (cmd_valid),
    .dbus_cmd_ready           (cmd_ready),
    .dbus_cmd_payload_wr      (cmd_wr),
    .dbus_cmd_payload_address (cmd_addr),
    .dbus_cmd_payload_data    (cmd_data),
    .dbus_cmd_payload_size    (cmd_size),
    .dbus_rsp_ready           (rsp_ready),
    .dbus_rsp_error           (rsp_error),
    .dbus_rsp_data            (rsp_data),
    .busy                     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // dBus side: command acceptance with optional stall, then a responder one cycle later.
  initial begin : bus_side
    int  stall;
    int  held;
    bit  acc_pend;
    cmd_t e;
    stall = 0; held = 0; acc_pend = 1'b0;
    cmd_ready = 1'b1; rsp_ready = 1'b0; rsp_error = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      rsp_ready = 1'b0;
      rsp_error = 1'b0;
      if (acc_pend) begin
        acc_pend = 1'b0;
        if (rsp_mode != 2) begin
          rsp_ready = 1'b1;
          rsp_error = (rsp_mode == 1);
          rsp_data  = rsp_word;
        end
      end
      if (resetn && cmd_valid) begin
        if (held == 0) stall = stall_req;
        held++;
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", 32'd1, 32'd0);
          cmd_ready = 1'b1;
          held = 0;
        end else begin
          e = exp_cmd[0];
          check("cmd_wr", {31'd0, cmd_wr}, {31'd0, e.wr});
          check("cmd_addr", cmd_addr, e.addr);
          check("cmd_size", {30'd0, cmd_size}, 32'd2);
          if (e.wr) check("cmd_data", cmd_data, e.data);
          cmd_ready = (stall == 0);
          if (stall > 0) stall--;
          if (cmd_ready) begin
            check("cmd_hold_cycles", held, {24'd0, e.hold});
            void'(exp_cmd.pop_front());
            held = 0;
            if (!e.wr) acc_pend = 1'b1;
          end
        end
      end else begin
        held = 0;
        cmd_ready = 1'b1;
      end
    end
  end

  // UART TX side: checks each pulse, then drops tx_rdy for tx_gap cycles.
  initial begin : tx_side
    int busy_cnt;
    bit prev;
    busy_cnt = 0; prev = 1'b0; tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_vld) begin
        check("tx_pulse_width", {31'd0, prev}, 32'd0);
        check("tx_rdy_at_vld", {31'd0, tx_rdy}, 32'd1);
        if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        tx_rdy = 1'b0;
        busy_cnt = tx_gap;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_rdy = 1'b1;
      end
      prev = tx_vld;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (op == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [7:0] h);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d; c.hold = h;
    exp_cmd.push_back(c);
  endtask

  task automatic push_read_reply(input logic [31:0] w);
    exp_tx.push_back(8'h06);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && exp_cmd.size() == 0) break;
    end
    check(tag, {31'd0, (i < budget)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_vld"}, {31'd0, tx_vld}, 32'd0);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr"}, cmd_addr, 32'd0);
  endtask

  initial begin : main
    int k;
    n_checks = 0; n_pass = 0; stall_req = 0; rsp_mode = 0; rsp_word = '0; tx_gap = 2;
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_size", {30'd0, cmd_size}, 32'd2);
    check("reset_wr", {31'd0, cmd_wr}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write
    push_cmd(1'b1, 32'h8000000C, 32'h0000000F, 8'd1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h8000000C, 32'h0000000F);
    wait_done("done_write", 200);

    // Basic read
    rsp_mode = 0; rsp_word = 32'hDEADBEEF;
    push_cmd(1'b0, 32'h00000010, 32'h0, 8'd1);
    push_read_reply(32'hDEADBEEF);
    send_frame(8'h52, 32'h00000010, 32'h0);
    wait_done("done_read", 300);

    // Unaligned address low bits are cleared on the bus
    push_cmd(1'b1, 32'h00000104, 32'hA5A55A5A, 8'd1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h00000107, 32'hA5A55A5A);
    wait_done("done_unaligned", 200);

    // Command backpressure for 7 cycles
    stall_req = 7;
    push_cmd(1'b1, 32'h12340100, 32'h12345678, 8'd8);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h12340100, 32'h12345678);
    wait_done("done_backpressure", 300);
    stall_req = 0;

    // Read error response
    rsp_mode = 1;
    push_cmd(1'b0, 32'h00000020, 32'h0, 8'd1);
    exp_tx.push_back(8'h15);
    send_frame(8'h52, 32'h00000020, 32'h0);
    wait_done("done_rsp_error", 300);

    // No response at all
    rsp_mode = 2;
    push_cmd(1'b0, 32'h00000024, 32'h0, 8'd1);
    exp_tx.push_back(8'h15);
    send_frame(8'h52, 32'h00000024, 32'h0);
    wait_done("done_rsp_timeout", RTO + 300);
    rsp_mode = 0;

    // Unknown opcode
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_done("done_bad_opcode", 200);

    // Inter-byte gap aborts the partial frame
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (BTO + 5) @(negedge clk);
    check("gap_abort_idle", {31'd0, busy}, 32'd0);
    rsp_word = 32'h01020304;
    push_cmd(1'b0, 32'h00000030, 32'h0, 8'd1);
    push_read_reply(32'h01020304);
    send_frame(8'h52, 32'h00000030, 32'h0);
    wait_done("done_after_gap", 300);

    // Reset during DATA
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    #2 resetn = 1'b0;
    #1 check_quiet("rst_data");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    push_cmd(1'b1, 32'h00000040, 32'hCAFEF00D, 8'd1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h00000040, 32'hCAFEF00D);
    wait_done("done_after_rst_data", 200);

    // Reset during REPLY, after the first byte has gone out
    tx_gap = 30;
    rsp_word = 32'h55667788;
    push_cmd(1'b0, 32'h00000050, 32'h0, 8'd1);
    push_read_reply(32'h55667788);
    send_frame(8'h52, 32'h00000050, 32'h0);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_tx.size() == 4) break;
    end
    check("rst_reply_first_byte", {31'd0, (k < 400)}, 32'd1);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    exp_tx.delete();
    #1 check_quiet("rst_reply");
    repeat (40) @(negedge clk);
    resetn = 1'b1;
    tx_gap = 2;
    repeat (40) @(negedge clk);
    rsp_word = 32'h0BADF00D;
    push_cmd(1'b0, 32'h00000060, 32'h0, 8'd1);
    push_read_reply(32'h0BADF00D);
    send_frame(8'h52, 32'h00000060, 32'h0);
    wait_done("done_after_rst_reply", 300);

    check("cmd_queue_empty", exp_cmd.size(), 32'd0);
    check("tx_queue_empty", exp_tx.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
